// File: rtl/tausworthe_urng.sv
// Uniform random source for the Box-Muller noise path: three combined taus88
// generators stepped twice per request, producing a 48-bit u0 and a 16-bit u1.
module tausworthe_urng #(
    parameter logic [31:0] SEED0 = 32'h0000_1234,
    parameter logic [31:0] SEED1 = 32'h0000_5678,
    parameter logic [31:0] SEED2 = 32'h0009_ABCD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_load,
    input  logic [95:0] seed_data,
    input  logic        urng_start,
    output logic        urng_done,
    output logic [47:0] u0,
    output logic [15:0] u1
);

    typedef enum logic [1:0] {
        StIdle,
        StGenA,
        StGenB,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] s0_q, s0_d;
    logic [31:0] s1_q, s1_d;
    logic [31:0] s2_q, s2_d;
    logic [31:0] a_q, a_d;
    logic [47:0] u0_q, u0_d;
    logic [15:0] u1_q, u1_d;
    logic        done_q, done_d;

    logic [31:0] s0_nx, s1_nx, s2_nx;
    logic [31:0] taus_out;
    logic [31:0] seed0_in, seed1_in, seed2_in;

    function automatic logic [31:0] step_s0(input logic [31:0] s);
        return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
    endfunction

    function automatic logic [31:0] step_s1(input logic [31:0] s);
        return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
    endfunction

    function automatic logic [31:0] step_s2(input logic [31:0] s);
        return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
    endfunction

    always_comb begin
        s0_nx    = step_s0(s0_q);
        s1_nx    = step_s1(s1_q);
        s2_nx    = step_s2(s2_q);
        taus_out = s0_nx ^ s1_nx ^ s2_nx;
    end

    // Seeds below a component's minimum would collapse it to a degenerate cycle.
    always_comb begin
        seed0_in = (seed_data[95:64] < 32'd2)  ? SEED0 : seed_data[95:64];
        seed1_in = (seed_data[63:32] < 32'd8)  ? SEED1 : seed_data[63:32];
        seed2_in = (seed_data[31:0]  < 32'd16) ? SEED2 : seed_data[31:0];
    end

    always_comb begin
        state_d = state_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        a_d     = a_q;
        u0_d    = u0_q;
        u1_d    = u1_q;
        done_d  = 1'b0;

        if (seed_load) begin
            s0_d    = seed0_in;
            s1_d    = seed1_in;
            s2_d    = seed2_in;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (urng_start) begin
                        state_d = StGenA;
                    end
                end
                StGenA: begin
                    s0_d    = s0_nx;
                    s1_d    = s1_nx;
                    s2_d    = s2_nx;
                    a_d     = taus_out;
                    state_d = StGenB;
                end
                StGenB: begin
                    s0_d    = s0_nx;
                    s1_d    = s1_nx;
                    s2_d    = s2_nx;
                    u0_d    = {a_q, taus_out[31:16]};
                    u1_d    = taus_out[15:0];
                    done_d  = 1'b1;
                    state_d = StDone;
                end
                StDone: begin
                    state_d = urng_start ? StGenA : StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            s0_q    <= SEED0;
            s1_q    <= SEED1;
            s2_q    <= SEED2;
            a_q     <= 32'd0;
            u0_q    <= 48'd0;
            u1_q    <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            a_q     <= a_d;
            u0_q    <= u0_d;
            u1_q    <= u1_d;
            done_q  <= done_d;
        end
    end

    assign urng_done = done_q;
    assign u0        = u0_q;
    assign u1        = u1_q;

endmodule

// File: tb/tb_tausworthe_urng.sv
// Self-checking bench for tausworthe_urng: a taus88 reference model feeds a
// scoreboard of expected {u0,u1} samples that are popped on each done pulse.
module tb_tausworthe_urng;

    localparam logic [31:0] SEED0 = 32'h0000_1234;
    localparam logic [31:0] SEED1 = 32'h0000_5678;
    localparam logic [31:0] SEED2 = 32'h0009_ABCD;
    localparam int unsigned Bound = 20;

    logic        clk;
    logic        reset;
    logic        seed_load;
    logic [95:0] seed_data;
    logic        urng_start;
    logic        urng_done;
    logic [47:0] u0;
    logic [15:0] u1;

    int unsigned total;
    int unsigned bad;

    logic [31:0] ms0, ms1, ms2;
    logic [63:0] exp_q[$];
    logic [63:0] first_smp;
    logic [63:0] last_out;

    tausworthe_urng dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed_data  (seed_data),
        .urng_start (urng_start),
        .urng_done  (urng_done),
        .u0         (u0),
        .u1         (u1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference taus88 step, written from the recurrence definitions.
    function automatic logic [31:0] ref_t0(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 13) ^ s) >> 19;
        return ((s & ~32'd1) << 12) ^ b;
    endfunction

    function automatic logic [31:0] ref_t1(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 2) ^ s) >> 25;
        return ((s & ~32'd7) << 4) ^ b;
    endfunction

    function automatic logic [31:0] ref_t2(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 3) ^ s) >> 11;
        return ((s & ~32'd15) << 17) ^ b;
    endfunction

    task automatic model_draw(output logic [31:0] r);
        ms0 = ref_t0(ms0);
        ms1 = ref_t1(ms1);
        ms2 = ref_t2(ms2);
        r   = ms0 ^ ms1 ^ ms2;
    endtask

    // {a, b} is exactly {u0, u1}.
    task automatic model_push();
        logic [31:0] a, b;
        model_draw(a);
        model_draw(b);
        exp_q.push_back({a, b});
    endtask

    task automatic model_seed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        ms0 = (a < 32'd2) ? SEED0 : a;
        ms1 = (b < 32'd8) ? SEED1 : b;
        ms2 = (c < 32'd16) ? SEED2 : c;
    endtask

    task automatic do_seed_load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        @(negedge clk);
        seed_load = 1'b1;
        seed_data = {a, b, c};
        @(negedge clk);
        seed_load = 1'b0;
        model_seed(a, b, c);
    endtask

    // Pulses start for one cycle; lat counts negedges until done (Bound on timeout).
    task automatic request(output int unsigned lat, output logic got);
        @(negedge clk);
        urng_start = 1'b1;
        @(negedge clk);
        urng_start = 1'b0;
        lat = 1;
        while (!urng_done && lat < Bound) begin
            @(negedge clk);
            lat++;
        end
        got = urng_done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_seed(SEED0, SEED1, SEED2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({urng_done, u0, u1} !== 65'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got done=%b u0=%h u1=%h want 0/0/0",
                         i, urng_done, u0, u1);
            end
        end
    endtask

    task automatic test_known_seed();
        int unsigned lat;
        logic        got;
        logic [63:0] e;
        do_seed_load(32'd2, 32'd8, 32'd16);
        model_push();
        request(lat, got);
        e = exp_q.pop_front();
        total++;
        if (!got || lat != 3) begin
            bad++;
            $display("FAIL known_latency got done=%b lat=%0d want 1/3", got, lat);
        end
        total++;
        if (u0 !== 48'h0020_2080_0200 || u1 !== 16'h2C80) begin
            bad++;
            $display("FAIL known_value got u0=%h u1=%h want 002020800200/2c80", u0, u1);
        end
        total++;
        if ({u0, u1} !== e) begin
            bad++;
            $display("FAIL known_model got %h want %h", {u0, u1}, e);
        end
        @(negedge clk);
        total++;
        if (urng_done !== 1'b0 || {u0, u1} !== e) begin
            bad++;
            $display("FAIL known_hold got done=%b out=%h want 0/%h", urng_done, {u0, u1}, e);
        end
        last_out = e;
    endtask

    task automatic test_back_to_back();
        int unsigned pulses;
        int unsigned pos[$];
        logic [63:0] e;
        pulses = 0;
        repeat (3) model_push();
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c > 0 && urng_done) begin
                pulses++;
                pos.push_back(c);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                total++;
                if ({u0, u1} !== e) begin
                    bad++;
                    $display("FAIL b2b_sample n=%0d got %h want %h", pulses, {u0, u1}, e);
                end
                last_out = e;
            end
            urng_start = (c < 9);
        end
        urng_start = 1'b0;
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL b2b_count got %0d want 3", pulses);
        end
        total++;
        if (pos.size() != 3 || pos[0] != 3 || pos[1] != 6 || pos[2] != 9) begin
            bad++;
            $display("FAIL b2b_spacing got %p want '{3,6,9}", pos);
        end
        exp_q.delete();
    endtask

    task automatic test_seed_abort();
        int unsigned lat;
        logic        got;
        logic        seen;
        logic [63:0] e;
        @(negedge clk);
        urng_start = 1'b1;
        @(negedge clk);
        urng_start = 1'b0;
        @(negedge clk);
        // The edge after this negedge falls in GEN_B.
        seed_load = 1'b1;
        seed_data = {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
        model_seed(32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seed_load = 1'b0;
            seen |= urng_done;
            total++;
            if ({u0, u1} !== last_out) begin
                bad++;
                $display("FAIL abort_hold cyc=%0d got %h want %h", i, {u0, u1}, last_out);
            end
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_nodone got done seen=%b want 0", seen);
        end
        model_push();
        request(lat, got);
        e = exp_q.pop_front();
        total++;
        if (!got || lat != 3 || {u0, u1} !== e) begin
            bad++;
            $display("FAIL abort_next got done=%b lat=%0d out=%h want 1/3/%h",
                     got, lat, {u0, u1}, e);
        end
    endtask

    task automatic test_illegal_seed();
        int unsigned lat;
        logic        got;
        logic [63:0] e;
        do_seed_load(32'd1, 32'd5, 32'd3);
        model_push();
        request(lat, got);
        e = exp_q.pop_front();
        total++;
        if (!got || {u0, u1} !== e) begin
            bad++;
            $display("FAIL illegal_model got done=%b out=%h want 1/%h", got, {u0, u1}, e);
        end
        total++;
        if ({u0, u1} !== first_smp) begin
            bad++;
            $display("FAIL illegal_first got %h want %h", {u0, u1}, first_smp);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned lat;
        logic        got;
        logic        seen;
        @(negedge clk);
        urng_start = 1'b1;
        @(negedge clk);
        urng_start = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_seed(SEED0, SEED1, SEED2);
        total++;
        if ({urng_done, u0, u1} !== 65'd0) begin
            bad++;
            $display("FAIL midreset_clear got done=%b u0=%h u1=%h want 0/0/0",
                     urng_done, u0, u1);
        end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= urng_done;
        end
        total++;
        if (seen !== 1'b0 || {u0, u1} !== 64'd0) begin
            bad++;
            $display("FAIL midreset_idle got seen=%b out=%h want 0/0", seen, {u0, u1});
        end
        model_push();
        request(lat, got);
        total++;
        if (!got || lat != 3 || {u0, u1} !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL midreset_first got done=%b lat=%0d out=%h want 1/3/%h",
                     got, lat, {u0, u1}, first_smp);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        seed_load  = 1'b0;
        seed_data  = 96'd0;
        urng_start = 1'b0;
        last_out   = 64'd0;

        model_seed(SEED0, SEED1, SEED2);
        model_push();
        first_smp = exp_q.pop_front();

        test_reset();
        test_known_seed();
        test_back_to_back();
        test_seed_abort();
        test_illegal_seed();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
